// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of a single spi_master between NUM_REQ
// requesters. Latches the winner's TX byte, launches the master, monitors
// cs/sclk/miso to rebuild the received byte, and reports done/error pulses.
module spi_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [7:0]           rx_data,
  output logic [7:0]           spi_data_in,
  output logic                 spi_start_send,
  input  logic                 spi_cs,
  input  logic                 spi_sclk,
  input  logic                 spi_miso
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, XFER, FINISH} state_t;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    last, last_nx;
  logic [IDX_W-1:0]    win, win_nx;
  logic [IDX_W-1:0]    pick, cand;
  logic                found;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [3:0]          bit_cnt, bit_cnt_nx;
  logic [7:0]          shreg, shreg_nx;
  logic [7:0]          rx_nx, data_nx;
  logic [NUM_REQ-1:0]  grant_nx;
  logic                start_nx, done_nx, error_nx;
  logic                sclk_prev, sclk_rise;

  assign busy      = (state != IDLE);
  assign sclk_rise = spi_sclk & ~sclk_prev;

  // Round-robin winner: first active request after the last served one
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last) + k) % 32'(NUM_REQ));
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state and datapath update for the arbitration/transfer FSM
  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    data_nx    = spi_data_in;
    start_nx   = spi_start_send;
    cnt_nx     = cnt;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    rx_nx      = rx_data;
    last_nx    = last;
    win_nx     = win;
    done_nx    = 1'b0;
    error_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          win_nx   = pick;
          grant_nx = NUM_REQ'(1) << pick;
          data_nx  = req_data[{pick, 3'b000} +: 8];
          start_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!spi_cs) begin
          start_nx   = 1'b0;
          bit_cnt_nx = '0;
          shreg_nx   = '0;
          state_nx   = XFER;
        end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
          // Stalled launch: give up and demote this requester
          error_nx = 1'b1;
          grant_nx = '0;
          start_nx = 1'b0;
          last_nx  = win;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      XFER: begin
        // A final sclk rise coincident with cs release is still captured
        if (sclk_rise) begin
          shreg_nx = {shreg[6:0], spi_miso};
          if (bit_cnt != 4'd15) bit_cnt_nx = bit_cnt + 4'd1;
        end
        if (spi_cs) state_nx = FINISH;
      end
      FINISH: begin
        rx_nx    = shreg;
        done_nx  = 1'b1;
        error_nx = (bit_cnt != 4'd8);
        grant_nx = '0;
        last_nx  = win;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= '0;
      spi_data_in    <= '0;
      spi_start_send <= 1'b0;
      cnt            <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      rx_data        <= '0;
      last           <= IDX_W'(NUM_REQ - 1);
      win            <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      sclk_prev      <= 1'b0;
    end else begin
      state          <= state_nx;
      grant          <= grant_nx;
      spi_data_in    <= data_nx;
      spi_start_send <= start_nx;
      cnt            <= cnt_nx;
      bit_cnt        <= bit_cnt_nx;
      shreg          <= shreg_nx;
      rx_data        <= rx_nx;
      last           <= last_nx;
      win            <= win_nx;
      done           <= done_nx;
      error          <= error_nx;
      sclk_prev      <= spi_sclk;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: drives spi_arbiter with a behavioural SPI master stub and
// checks grants, launch timing, received bytes and pulses against a
// round-robin reference model kept in the bench.
module tb_spi_arbiter;

  localparam int NR  = 4;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   grant;
  logic            busy, done, error;
  logic [7:0]      rx_data, spi_data_in;
  logic            spi_start_send;
  logic            spi_cs, spi_sclk, spi_miso;

  logic [7:0] tx [NR];
  int         last_m;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  spi_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_data       (req_data),
    .grant          (grant),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .rx_data        (rx_data),
    .spi_data_in    (spi_data_in),
    .spi_start_send (spi_start_send),
    .spi_cs         (spi_cs),
    .spi_sclk       (spi_sclk),
    .spi_miso       (spi_miso)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration: rotate the doubled request vector so the search
  // starts just past the last served requester
  function automatic int rr_pick(input logic [NR-1:0] r, input int lst);
    logic [2*NR-1:0] dbl;
    dbl = {r, r} >> (lst + 1);
    for (int k = 0; k < NR; k++)
      if (dbl[k]) return (lst + 1 + k) % NR;
    return 0;
  endfunction

  task automatic pack();
    for (int i = 0; i < NR; i++) req_data[8*i +: 8] = tx[i];
  endtask

  task automatic check_reset_state();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_data_in", 32'(spi_data_in), 0);
    check("rst_start", 32'(spi_start_send), 0);
  endtask

  // One full transfer; entered at a falling edge with the arbiter idle and
  // req already set, leaves at the falling edge where done is high.
  task automatic run_xfer(input int nbits, input logic [15:0] mw, input int ldelay,
                          input bit cs_same, input bit rel, input bit scramble);
    int          w;
    logic [7:0]  exp_tx, mosi;
    logic [15:0] sh;
    w      = rr_pick(req, last_m);
    exp_tx = tx[w];
    @(negedge clk);
    check("grant", 32'(grant), 32'(1) << w);
    check("data_in", 32'(spi_data_in), 32'(exp_tx));
    check("start_send", 32'(spi_start_send), 1);
    check("busy", 32'(busy), 1);
    check("done_low", 32'(done), 0);
    check("error_low", 32'(error), 0);
    if (rel) req[w] = 1'b0;
    if (scramble) req_data = $urandom();
    repeat (ldelay) @(negedge clk);
    spi_cs = 1'b0;
    @(negedge clk);
    check("start_fall", 32'(spi_start_send), 0);
    mosi = '0;
    for (int b = 0; b < nbits; b++) begin
      spi_miso = mw[15-b];
      @(negedge clk);
      spi_sclk = 1'b1;
      if (b < 8) mosi = {mosi[6:0], spi_data_in[7-b]};
      if (cs_same && b == nbits - 1) spi_cs = 1'b1;
      @(negedge clk);
      spi_sclk = 1'b0;
    end
    if (!cs_same) begin
      spi_cs = 1'b1;
      @(negedge clk);
    end
    check("done_early", 32'(done), 0);
    @(negedge clk);
    sh = mw >> (16 - nbits);
    check("done", 32'(done), 1);
    check("rx_data", 32'(rx_data), 32'(sh[7:0]));
    check("error", 32'(error), (nbits != 8) ? 1 : 0);
    check("grant_clr", 32'(grant), 0);
    check("busy_clr", 32'(busy), 0);
    if (nbits >= 8) check("mosi", 32'(mosi), 32'(exp_tx));
    last_m = w;
  endtask

  // Launch with cs never asserting; leaves at the falling edge showing error
  task automatic run_timeout();
    int w, n;
    w = rr_pick(req, last_m);
    @(negedge clk);
    check("tmo_grant", 32'(grant), 32'(1) << w);
    req[w] = 1'b0;
    n = 0;
    while (spi_start_send === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_len", n, TMO);
    check("tmo_error", 32'(error), 1);
    check("tmo_grant_clr", 32'(grant), 0);
    check("tmo_done", 32'(done), 0);
    check("tmo_busy", 32'(busy), 0);
    last_m = w;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    spi_cs   = 1'b1;
    spi_sclk = 1'b0;
    spi_miso = 1'b0;
    last_m   = NR - 1;
    for (int i = 0; i < NR; i++) tx[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    // Round robin with all requests held
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
    pack();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) run_xfer(8, 16'($urandom()), i % 3, 1'b0, 1'b0, 1'b0);
    req = '0;

    // Single request
    tx[0] = 8'hAA;
    pack();
    req = 4'b0001;
    run_xfer(8, 16'h5C00, 1, 1'b0, 1'b1, 1'b0);

    // Priority rotation
    req = 4'b0100;
    run_xfer(8, 16'h1200, 0, 1'b0, 1'b1, 1'b0);
    req = 4'b0101;
    run_xfer(8, 16'h3400, 2, 1'b0, 1'b1, 1'b0);
    run_xfer(8, 16'h5600, 0, 1'b0, 1'b1, 1'b0);
    req = 4'b1100;
    run_xfer(8, 16'h7800, 1, 1'b0, 1'b1, 1'b0);

    // Short frame, then sclk rise coincident with cs release
    req = 4'b0001;
    run_xfer(5, 16'hB000, 0, 1'b0, 1'b1, 1'b0);
    req = 4'b0100;
    run_xfer(8, 16'h3A00, 0, 1'b1, 1'b1, 1'b0);

    // Launch timeout, then the next requester is served
    req = 4'b0011;
    run_timeout();
    run_xfer(8, 16'hC300, 0, 1'b0, 1'b1, 1'b0);

    // Reset during bit 4
    tx[0] = 8'h3C;
    pack();
    req = 4'b0001;
    @(negedge clk);
    check("mid_grant", 32'(grant), 1);
    req    = '0;
    spi_cs = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      spi_miso = 1'($urandom());
      @(negedge clk);
      spi_sclk = 1'b1;
      @(negedge clk);
      spi_sclk = 1'b0;
    end
    spi_miso = 1'b1;
    @(negedge clk);
    spi_sclk = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    reset    = 1'b0;
    spi_cs   = 1'b1;
    spi_sclk = 1'b0;
    last_m   = NR - 1;
    tx[1]    = 8'h96;
    pack();
    req = 4'b0010;
    run_xfer(8, 16'hE700, 2, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NR; i++) tx[i] = 8'($urandom());
      pack();
      req = 4'($urandom_range(1, 15));
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 8;
      run_xfer(nb, 16'($urandom()), int'($urandom_range(0, 4)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end
    req = '0;
    @(negedge clk);
    check("final_done_low", 32'(done), 0);
    check("final_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares one `spi_master` between `NUM_REQ` requesters on a round-robin basis. The block latches the winning requester's byte and drives the master's `data_in` and `start_send`. It tracks the transfer by monitoring the master's `cs`, `sclk` and `miso` lines, and returns the received byte with a one-cycle `done` pulse. It sits directly between client logic and `spi_master`, and is the only driver of the master's command inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `START_TIMEOUT`, 64: maximum `clk` cycles `start_send` is held waiting for `cs` to assert before the launch is abandoned.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester transfer request, level; held until the matching `grant` bit is seen.
- `req_data`  in  8*NUM_REQ  TX byte of requester i at bits [8i+7:8i]; sampled only at grant.
- `grant`  out  NUM_REQ  one-hot; the owning requester, high from grant to end of transfer.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse: transfer finished, `rx_data` valid.
- `error`  out  1  one-cycle pulse: launch timeout or bad bit count.
- `rx_data`  out  8  last received byte; holds until the next `done`.
- `spi_data_in`  out  8  to master `data_in`.
- `spi_start_send`  out  1  to master `start_send`.
- `spi_cs`  in  1  from master `cs`, active-low.
- `spi_sclk`  in  1  from master `sclk`.
- `spi_miso`  in  1  the shared `miso` line, monitored.

## Operation
- SPI mode 0 and MSB first are fixed. `miso` is sampled on each `sclk` rising edge while `cs` is low.
- The state machine has four states: IDLE, LAUNCH, XFER, FINISH.
- **IDLE.** If any `req` bit is high, pick the winner.
  - Search from requester `(last+1) mod NUM_REQ` upward, wrapping; `last` is the previously served requester.
  - Register the one-hot winner into `grant` and its byte into `spi_data_in`, then go to LAUNCH.
- **LAUNCH.**
  - `spi_start_send` is 1 and the cycle counter increments.
  - On `spi_cs`==0, go to XFER, clear `spi_start_send`, and clear the bit counter and shift register.
  - If the counter reaches `START_TIMEOUT` first:
    - pulse `error` and clear `grant` and `spi_start_send`;
    - set `last` to the current winner so the stalled requester loses priority;
    - go to IDLE.
- **XFER.**
  - Edge detection uses the registered previous `spi_sclk`.
  - On each rising edge, shift `spi_miso` into the LSB of the shift register and increment the 4-bit bit counter, which saturates at 15.
  - On `spi_cs` returning high, go to FINISH.
- **FINISH.** Takes one cycle.
  - Load `rx_data` from the shift register and pulse `done`.
  - Pulse `error` as well if the bit count is not 8.
  - Clear `grant`, set `last` to the winner, and go to IDLE.
- A `req` deasserted while granted is ignored; the transfer completes.
- `req_data` changes after grant have no effect.
- `spi_data_in` holds its value until the next grant.
- Reset forces IDLE immediately, from any state, including mid-transfer.
  - Reset values: `grant`=0, `busy`=0, `done`=0, `error`=0, `rx_data`=0, `spi_data_in`=0, `spi_start_send`=0.
  - Counters are cleared.
  - `last`=NUM_REQ-1, so requester 0 has first priority.
  - The master is reset by the same `reset`.

## Timing
- Edge 0 samples `req` in IDLE. `grant`, `spi_data_in` and `spi_start_send` are valid after edge 1.
- `spi_start_send` falls on the edge after `spi_cs`=0 is sampled, and is never held more than `START_TIMEOUT` cycles.
- `done` is high for the single cycle after the edge following the sampled `spi_cs` rise. `grant` drops on that same edge.
- Back-to-back service: a pending request is granted on the edge after FINISH. There is one IDLE cycle, so `grant` is low for one cycle between owners.
- `busy` rises with `grant` and falls with `done`/`error`.
- Inputs `spi_cs`, `spi_sclk` and `spi_miso` are synchronous to `clk`; there is no synchronizer.
- An `sclk` rising edge and the `cs` rise in the same cycle: the bit is still shifted before FINISH.

## Test plan
- **Single request.** `req`=0001, `req_data[7:0]`=8'hAA, MISO model returns 8'h5C.
  - `grant`=0001 one cycle later, `spi_data_in`=AA.
  - MOSI carries 10101010.
  - `done` pulses once, `rx_data`=5C, `error`=0.
- **Round robin.** `req`=1111 held continuously, bytes 11/22/33/44.
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - A one-cycle `grant` gap between owners; each MOSI byte matches its owner.
- **Priority rotation.**
  - Serve requester 2; then raise `req`=0101 together → requester 2 is not granted next, requester 0 wins.
  - Then request 2 and 3 together → 3 wins.
- **Launch timeout.** `START_TIMEOUT`=8 and `spi_cs` forced high.
  - `spi_start_send` is high for exactly 8 cycles, then `error` pulses.
  - `grant` clears, `done` stays 0, and the next requester is served.
- **Reset mid-transfer.** Assert `reset` for 2 cycles during bit 4.
  - All outputs return to reset values within one edge.
  - After release, `req`=0010 is granted and completes normally, with the correct `rx_data`.
- **Short frame.** Stub master drops `cs` after 5 `sclk` edges.
  - `done` and `error` pulse in the same cycle.
  - `rx_data` holds the 5 captured bits in [4:0].
